// File: rtl/emu_sched_pkg.sv
// Shared types and helpers for the emulation step scheduler.
package emu_sched_pkg;

  // Scheduler states, one emulated NoC cycle per READY -> ... -> READY loop.
  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    READY  = 3'd1,
    TX     = 3'd2,
    WAIT   = 3'd3,
    PULL   = 3'd4,
    CLK_HI = 3'd5,
    CLK_LO = 3'd6,
    ERROR  = 3'd7
  } state_t;

  // Width of the shared down-counter. It must hold max(T, H, L) - 1,
  // which $clog2(max) bits always do; never narrower than one bit.
  function automatic int timer_width(input int timeout_cycles,
                                     input int high_cycles,
                                     input int low_cycles);
    int m;
    m = timeout_cycles;
    if (high_cycles > m) m = high_cycles;
    if (low_cycles > m)  m = low_cycles;
    if ($clog2(m) < 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/emu_step_scheduler.sv
// Sequences one emulated NoC clock cycle across all LVDS gates of a
// partition: sync, TX launch, handshake wait, RX pull, then one full
// high/low period of the emulation clock.
module emu_step_scheduler
  import emu_sched_pkg::*;
#(
  parameter int GATE_NUMBER     = 1,
  parameter int CLK_HIGH_CYCLES = 2,
  parameter int CLK_LOW_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_step,
  input  logic [GATE_NUMBER-1:0] i_sync_done,
  input  logic [GATE_NUMBER-1:0] i_tx_ready,
  input  logic [GATE_NUMBER-1:0] i_rx_ready,
  output logic                   o_gen_sync,
  output logic                   o_tx_start,
  output logic                   o_rx_pull,
  output logic                   o_clock,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic [CNT_WIDTH-1:0]   o_cycle_count
);

  localparam int TW = timer_width(TIMEOUT_CYCLES, CLK_HIGH_CYCLES, CLK_LOW_CYCLES);

  // Reload values: a phase of N cycles loads N-1 and ends when the counter is 0.
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HIGH_LOAD    = TW'(CLK_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD     = TW'(CLK_LOW_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [TW-1:0]        r_timer;
  logic                 w_timer_zero;
  logic                 w_sync_all;
  logic                 w_xfer_all;

  logic                 w_gen_sync_next;
  logic                 w_tx_start_next;
  logic                 w_rx_pull_next;
  logic                 w_clock_next;
  logic                 w_busy_next;
  logic                 w_timeout_next;
  logic                 w_count_inc;

  logic                 r_gen_sync;
  logic                 r_tx_start;
  logic                 r_rx_pull;
  logic                 r_clock;
  logic                 r_busy;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_cycle_count;

  // Gate-wide handshake conditions: every bridge must agree.
  assign w_sync_all   = &i_sync_done;
  assign w_xfer_all   = (&i_tx_ready) & (&i_rx_ready);
  assign w_timer_zero = (r_timer == '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= SYNC;
    else        r_state <= w_state_next;
  end

  // Next-state logic. Clock phases never look at sync so o_clock cannot
  // produce a runt pulse; link loss is acted on once back in READY.
  // NOTE: every combinational output gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      SYNC:   if (w_sync_all) w_state_next = READY;
      READY: begin
        if (!w_sync_all)            w_state_next = SYNC;
        else if (i_start || i_step) w_state_next = TX;
      end
      TX:     w_state_next = WAIT;
      WAIT: begin
        if (w_xfer_all)        w_state_next = PULL;
        else if (w_timer_zero) w_state_next = ERROR;
        else if (!w_sync_all)  w_state_next = SYNC;
      end
      PULL:   w_state_next = CLK_HI;
      CLK_HI: if (w_timer_zero) w_state_next = CLK_LO;
      CLK_LO: if (w_timer_zero) w_state_next = READY;
      ERROR:  w_state_next = ERROR;
      default: w_state_next = SYNC;
    endcase
  end

  // Output decode from the next state, so the registered outputs change
  // on the same edge as the state they describe.
  always_comb begin
    w_gen_sync_next = (w_state_next == SYNC);
    w_tx_start_next = (w_state_next == TX);
    w_rx_pull_next  = (w_state_next == PULL);
    w_clock_next    = (w_state_next == CLK_HI);
    w_busy_next     = (w_state_next != READY);
    w_timeout_next  = (w_state_next == ERROR);
    w_count_inc     = (w_state_next == CLK_HI) && (r_state != CLK_HI);
  end

  // Shared down-counter: WAIT timeout budget, then high and low phase lengths.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_timer <= '0;
    end else if (w_state_next != r_state) begin
      unique case (w_state_next)
        WAIT:    r_timer <= TIMEOUT_LOAD;
        CLK_HI:  r_timer <= HIGH_LOAD;
        CLK_LO:  r_timer <= LOW_LOAD;
        default: r_timer <= '0;
      endcase
    end else if (!w_timer_zero) begin
      r_timer <= r_timer - TW'(1);
    end
  end

  // Output registers; reset forces o_clock low asynchronously.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_gen_sync    <= 1'b1;
      r_tx_start    <= 1'b0;
      r_rx_pull     <= 1'b0;
      r_clock       <= 1'b0;
      r_busy        <= 1'b1;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_gen_sync <= w_gen_sync_next;
      r_tx_start <= w_tx_start_next;
      r_rx_pull  <= w_rx_pull_next;
      r_clock    <= w_clock_next;
      r_busy     <= w_busy_next;
      r_timeout  <= w_timeout_next;
      if (w_count_inc) r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
    end
  end

  assign o_gen_sync    = r_gen_sync;
  assign o_tx_start    = r_tx_start;
  assign o_rx_pull     = r_rx_pull;
  assign o_clock       = r_clock;
  assign o_busy        = r_busy;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_emu_step_scheduler.sv
// Directed bench for emu_step_scheduler. The handshake inputs are reduced
// combinationally (no extra input register stage), so all latencies are
// the unshifted figures: one edge from sampled input to registered output.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_emu_step_scheduler;

  localparam int GN  = 2;
  localparam int CW  = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_step;
  logic [GN-1:0] i_sync_done;
  logic [GN-1:0] i_tx_ready;
  logic [GN-1:0] i_rx_ready;
  logic          o_gen_sync;
  logic          o_tx_start;
  logic          o_rx_pull;
  logic          o_clock;
  logic          o_busy;
  logic          o_timeout;
  logic [CW-1:0] o_cycle_count;

  int n_checks = 0;
  int n_pass   = 0;
  int tx_pulses = 0;
  int rx_pulses = 0;

  emu_step_scheduler #(
    .GATE_NUMBER     (GN),
    .CLK_HIGH_CYCLES (2),
    .CLK_LOW_CYCLES  (2),
    .TIMEOUT_CYCLES  (16),
    .CNT_WIDTH       (CW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_step        (i_step),
    .i_sync_done   (i_sync_done),
    .i_tx_ready    (i_tx_ready),
    .i_rx_ready    (i_rx_ready),
    .o_gen_sync    (o_gen_sync),
    .o_tx_start    (o_tx_start),
    .o_rx_pull     (o_rx_pull),
    .o_clock       (o_clock),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_cycle_count (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_tx_start) tx_pulses = tx_pulses + 1;
    if (o_rx_pull)  rx_pulses = rx_pulses + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            gs;
    int            tx0;
    int            rx0;
    logic [31:0]   cnt0;
    logic [23:0]   clk_trace;
    logic [23:0]   tx_trace;

    i_rst       = 1'b0;
    i_start     = 1'b0;
    i_step      = 1'b0;
    i_sync_done = 2'b01;
    i_tx_ready  = 2'b00;
    i_rx_ready  = 2'b00;
    clk_trace   = '0;
    tx_trace    = '0;
    tick();
    tick();

    // Reset state.
    check("rst_gen_sync", o_gen_sync, 1);
    check("rst_busy",     o_busy,     1);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_rx_pull",  o_rx_pull,  0);
    check("rst_clock",    o_clock,    0);
    check("rst_timeout",  o_timeout,  0);
    check("rst_count",    o_cycle_count, 0);

    // Release with one gate not synced for 10 cycles, then both.
    i_rst = 1'b1;
    gs = 0;
    repeat (10) begin
      gs = gs + int'(o_gen_sync);
      tick();
    end
    i_sync_done = 2'b11;
    gs = gs + int'(o_gen_sync);
    tick();
    check("sync_high_cycles", gs, 11);
    check("ready_gen_sync",   o_gen_sync, 0);
    check("ready_busy",       o_busy,     0);

    // Single step; handshake returns 5 cycles after the TX pulse.
    tx0 = tx_pulses;
    rx0 = rx_pulses;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    check("step_tx_start", o_tx_start, 1);
    check("step_tx_busy",  o_busy,     1);
    tick();
    check("step_wait_tx_low", o_tx_start, 0);
    repeat (4) tick();
    check("step_wait_no_pull",  o_rx_pull, 0);
    check("step_wait_no_clock", o_clock,   0);
    i_tx_ready = 2'b11;
    i_rx_ready = 2'b11;
    tick();
    check("step_pull", o_rx_pull, 1);
    check("step_pull_clock", o_clock, 0);
    i_tx_ready = 2'b00;
    i_rx_ready = 2'b00;
    tick();
    check("step_hi1_clock", o_clock, 1);
    check("step_hi1_count", o_cycle_count, 1);
    tick();
    check("step_hi2_clock", o_clock, 1);
    tick();
    check("step_lo1_clock", o_clock, 0);
    tick();
    check("step_lo2_clock", o_clock, 0);
    check("step_lo2_busy",  o_busy,  1);
    tick();
    check("step_done_busy",  o_busy, 0);
    check("step_done_count", o_cycle_count, 1);
    check("step_tx_pulses",  tx_pulses - tx0, 1);
    check("step_rx_pulses",  rx_pulses - rx0, 1);

    // Free run for three loops with handshake ready immediately:
    // per loop TX,WAIT,PULL,HI,HI,LO,LO,READY = 8 cycles.
    tx0 = tx_pulses;
    rx0 = rx_pulses;
    i_tx_ready = 2'b11;
    i_rx_ready = 2'b11;
    i_start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      clk_trace = {clk_trace[22:0], o_clock};
      tx_trace  = {tx_trace[22:0], o_tx_start};
      if (k == 19) i_start = 1'b0;
    end
    check("run_clock_trace", clk_trace, {3{8'b00011000}});
    check("run_tx_trace",    tx_trace,  {3{8'b10000000}});
    check("run_count",       o_cycle_count, 4);
    check("run_busy",        o_busy, 0);
    check("run_tx_pulses",   tx_pulses - tx0, 3);
    check("run_rx_pulses",   rx_pulses - rx0, 3);
    i_tx_ready = 2'b00;
    i_rx_ready = 2'b00;

    // Sync loss during WAIT.
    cnt0 = o_cycle_count;
    rx0  = rx_pulses;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    tick();
    i_sync_done = 2'b10;
    tick();
    check("wloss_gen_sync", o_gen_sync, 1);
    check("wloss_busy",     o_busy,     1);
    check("wloss_clock",    o_clock,    0);
    tick();
    tick();
    check("wloss_no_pull", rx_pulses - rx0, 0);
    check("wloss_count",   o_cycle_count, cnt0);
    i_sync_done = 2'b11;
    tick();
    check("wloss_recover_busy", o_busy, 0);

    // Sync loss during CLK_HI: both phases still complete, then SYNC.
    i_tx_ready = 2'b11;
    i_rx_ready = 2'b11;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    tick();
    tick();
    tick();
    check("hloss_hi1_clock", o_clock, 1);
    check("hloss_count",     o_cycle_count, 5);
    i_sync_done = 2'b00;
    tick();
    check("hloss_hi2_clock", o_clock, 1);
    tick();
    check("hloss_lo1_clock", o_clock, 0);
    tick();
    check("hloss_lo2_clock", o_clock, 0);
    check("hloss_lo2_sync",  o_gen_sync, 0);
    tick();
    check("hloss_ready_busy", o_busy, 0);
    tick();
    check("hloss_sync_gen", o_gen_sync, 1);
    check("hloss_sync_busy", o_busy, 1);
    i_sync_done = 2'b11;
    tick();
    check("hloss_recover_busy", o_busy, 0);

    // Start and step together: a single TX; then reset mid CLK_HI.
    tx0 = tx_pulses;
    i_start = 1'b1;
    i_step  = 1'b1;
    tick();
    i_step = 1'b0;
    check("both_tx", o_tx_start, 1);
    tick();
    check("both_wait_tx_low", o_tx_start, 0);
    tick();
    check("both_pull", o_rx_pull, 1);
    tick();
    check("both_hi_clock", o_clock, 1);
    check("both_tx_pulses", tx_pulses - tx0, 1);
    i_start = 1'b0;
    #1;
    i_rst = 1'b0;
    #1;
    check("async_rst_clock", o_clock, 0);
    check("async_rst_count", o_cycle_count, 0);
    check("async_rst_sync",  o_gen_sync, 1);
    check("async_rst_busy",  o_busy, 1);
    tick();
    i_rst = 1'b1;
    tick();
    check("rerelease_busy", o_busy, 0);

    // Timeout: RX never ready, 16 WAIT cycles then ERROR.
    i_tx_ready = 2'b11;
    i_rx_ready = 2'b00;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    repeat (16) tick();
    check("to_last_wait_flag", o_timeout, 0);
    check("to_last_wait_busy", o_busy, 1);
    tick();
    check("to_flag",  o_timeout, 1);
    check("to_clock", o_clock, 0);
    check("to_busy",  o_busy, 1);
    tx0 = tx_pulses;
    rx0 = rx_pulses;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    i_rx_ready = 2'b11;
    repeat (3) tick();
    check("to_sticky",     o_timeout, 1);
    check("to_step_no_tx", tx_pulses - tx0, 0);
    check("to_no_pull",    rx_pulses - rx0, 0);
    check("to_busy_hold",  o_busy, 1);
    check("to_no_sync",    o_gen_sync, 0);
    i_rst = 1'b0;
    #1;
    check("to_rst_clear", o_timeout, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
